// File: rtl/dcache_responder.sv
// dcache_responder
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// fixed-latency main memory. Stall holds the core's PC (and its request
// inputs) until each access completes.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   mem_read    load request
//   mem_write   store request (wins over mem_read)
//   addr        word address {tag, index, offset}
//   write_data  store data
//   read_data   load data, valid in the cycle a read hits, 0 otherwise
//   stall       core must freeze while high
//   hit_count   saturating count of completed hits (read hits + store hits)
//   miss_count  saturating count of read misses
//
// state   | meaning
// S_IDLE  | accept a request; read hits are answered combinationally
// S_FILL  | block fetch from main memory, line written when cnt reaches 1
// S_WBUSY | store to main memory, committed when cnt reaches 1
module dcache_responder #(
   parameter int ADDR_W      = 10,
   parameter int LINES       = 16,
   parameter int WPB         = 4,
   parameter int MEM_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              stall,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);

   localparam int IDX_W = $clog2(LINES);
   localparam int OFF_W = $clog2(WPB);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WBUSY = 2'd2;

   logic [31:0]      main_mem  [2**ADDR_W];
   logic [31:0]      line_data [LINES][WPB];
   logic [TAG_W-1:0] line_tag  [LINES];
   logic [LINES-1:0] line_valid;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_data;

   logic [TAG_W-1:0] req_tag, lat_tag;
   logic [IDX_W-1:0] req_idx, lat_idx;
   logic [OFF_W-1:0] req_off;
   logic             read_hit, wr_line_hit, last_cycle, fill_done, wr_done;

   assign req_tag = addr[ADDR_W-1 -: TAG_W];
   assign req_idx = addr[OFF_W +: IDX_W];
   assign req_off = addr[OFF_W-1:0];
   assign lat_tag = lat_addr[ADDR_W-1 -: TAG_W];
   assign lat_idx = lat_addr[OFF_W +: IDX_W];

   assign read_hit    = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
   assign wr_line_hit = line_valid[lat_idx] && (line_tag[lat_idx] == lat_tag);
   assign last_cycle  = (cnt == CNT_W'(1));
   assign fill_done   = !rst && (state == S_FILL)  && last_cycle;
   assign wr_done     = !rst && (state == S_WBUSY) && last_cycle;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      stall     = 1'b0;
      read_data = '0;
      if (!rst) begin
         case (state)
            S_IDLE: begin
               if (mem_write) begin
                  stall = 1'b1;
               end else if (mem_read) begin
                  if (read_hit) read_data = line_data[req_idx][req_off];
                  else          stall     = 1'b1;
               end
            end
            S_FILL:  stall = 1'b1;
            // The store's final cycle releases the core so it advances in
            // lock-step with the memory commit.
            S_WBUSY: stall = !last_cycle;
            default: stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         line_valid <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_write) begin
                  lat_addr <= addr;
                  lat_data <= write_data;
                  cnt      <= CNT_W'(MEM_LATENCY);
                  state    <= S_WBUSY;
               end else if (mem_read) begin
                  if (read_hit) begin
                     hit_count <= sat_inc(hit_count);
                  end else begin
                     lat_addr   <= addr;
                     cnt        <= CNT_W'(MEM_LATENCY);
                     state      <= S_FILL;
                     miss_count <= sat_inc(miss_count);
                  end
               end
            end
            S_FILL: begin
               if (last_cycle) begin
                  line_valid[lat_idx] <= 1'b1;
                  cnt                 <= '0;
                  state               <= S_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_WBUSY: begin
               if (last_cycle) begin
                  if (wr_line_hit) hit_count <= sat_inc(hit_count);
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Arrays carry no reset; their commits are qualified by !rst so a store
   // or fill interrupted by reset leaves memory and the line untouched.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         line_tag[lat_idx] <= lat_tag;
         for (int w = 0; w < WPB; w++) begin
            line_data[lat_idx][w] <= main_mem[{lat_addr[ADDR_W-1:OFF_W], OFF_W'(w)}];
         end
      end
      if (wr_done) begin
         main_mem[lat_addr] <= lat_data;
         if (wr_line_hit) line_data[lat_idx][lat_addr[OFF_W-1:0]] <= lat_data;
      end
   end

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [9:0]  addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        stall;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int n_checks = 0;
   int n_pass   = 0;

   dcache_responder #(
      .ADDR_W(10), .LINES(16), .WPB(4), .MEM_LATENCY(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .write_data (write_data),
      .read_data  (read_data),
      .stall      (stall),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Called just after a rising edge; holds the read until stall drops.
   task automatic do_read(input logic [9:0] a, input logic [31:0] exp,
                          input int exp_stalls, input string tag);
      int n;
      n         = 0;
      mem_read  = 1'b1;
      mem_write = 1'b0;
      addr      = a;
      @(negedge clk);
      while (stall && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_stalls"}, n, exp_stalls);
      chk({tag, "_data"}, read_data, exp);
      @(posedge clk);
      #1 mem_read = 1'b0;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d,
                           input logic also_read, input string tag);
      int n;
      n          = 0;
      mem_write  = 1'b1;
      mem_read   = also_read;
      addr       = a;
      write_data = d;
      @(negedge clk);
      if (also_read) chk({tag, "_rd_zero"}, read_data, 32'h0);
      while (stall && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_stalls"}, n, 4);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      mem_read  = 1'b0;
   endtask

   // Preload without checking: every store here goes to an empty cache.
   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      int n;
      n          = 0;
      mem_write  = 1'b1;
      addr       = a;
      write_data = d;
      @(negedge clk);
      while (stall && n < 20) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      #1 mem_write = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr       = '0;
      write_data = '0;
      pulse_reset();

      preload(10'h010, 32'hDEADBEEF);
      preload(10'h011, 32'h11111111);
      preload(10'h013, 32'hCAFE0013);
      preload(10'h110, 32'h0BAD0110);
      preload(10'h020, 32'h00000020);
      pulse_reset();

      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_rdata", read_data, 0);
      chk("rst_hits", hit_count, 0);
      chk("rst_miss", miss_count, 0);
      @(posedge clk);
      #1;

      do_read(10'h010, 32'hDEADBEEF, 5, "miss_010");
      @(negedge clk);
      chk("t1_hits", hit_count, 1);
      chk("t1_miss", miss_count, 1);
      @(posedge clk);
      #1;

      do_read(10'h013, 32'hCAFE0013, 0, "hit_013");
      @(negedge clk);
      chk("t2_hits", hit_count, 2);
      @(posedge clk);
      #1;

      do_write(10'h011, 32'h12345678, 1'b0, "wr_011");
      do_read(10'h011, 32'h12345678, 0, "rd_011");
      @(negedge clk);
      chk("t3_hits", hit_count, 4);
      @(posedge clk);
      #1;

      do_write(10'h200, 32'hA5A50200, 1'b0, "wr_200");
      do_read(10'h200, 32'hA5A50200, 5, "rd_200");
      @(negedge clk);
      chk("t4_hits", hit_count, 5);
      chk("t4_miss", miss_count, 2);
      @(posedge clk);
      #1;

      // Reset in the middle of a store: memory at 0x010 must keep DEADBEEF.
      mem_write  = 1'b1;
      addr       = 10'h010;
      write_data = 32'hBADBAD00;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rstw_stall", stall, 0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      chk("rstw_next_stall", stall, 0);
      @(posedge clk);
      #1;

      // Reset during FILL cycle 2.
      mem_read = 1'b1;
      addr     = 10'h020;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rstf_stall", stall, 0);
      chk("rstf_rdata", read_data, 0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      mem_read = 1'b0;
      @(negedge clk);
      chk("rstf_next_stall", stall, 0);
      chk("rstf_miss", miss_count, 0);
      @(posedge clk);
      #1;

      do_read(10'h010, 32'hDEADBEEF, 5, "cf_a");
      do_read(10'h110, 32'h0BAD0110, 5, "cf_b");
      do_read(10'h010, 32'hDEADBEEF, 5, "cf_c");
      do_read(10'h011, 32'h12345678, 0, "cf_011");
      @(negedge clk);
      chk("cf_miss", miss_count, 3);
      chk("cf_hits", hit_count, 4);
      @(posedge clk);
      #1;

      do_write(10'h013, 32'h13131313, 1'b1, "rw_013");
      do_read(10'h013, 32'h13131313, 0, "rd_013");
      @(negedge clk);
      chk("end_hits", hit_count, 6);
      chk("end_miss", miss_count, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
